// File: rtl/chan_fifo_pkg.sv
// chan_fifo_pkg: shared channel/count types and drop-counter width for chan_fifo
package chan_fifo_pkg;
    localparam int CH_BITS_DEF   = 2;
    localparam int ADDR_BITS_DEF = 3;
    localparam int DROP_W        = 16;
    typedef logic [CH_BITS_DEF-1:0] ch_idx_t;
    typedef logic [ADDR_BITS_DEF:0] cnt_t;
endpackage

// File: rtl/chan_fifo_ptr.sv
// chan_fifo_ptr: per-channel read pointer, write pointer and occupancy count
module chan_fifo_ptr #(
    parameter int ADDR_BITS = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    output logic [ADDR_BITS-1:0] rptr,
    output logic [ADDR_BITS-1:0] wptr,
    output logic [ADDR_BITS:0]   count
);
    // pointers wrap naturally; count moves only when push and pop differ
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end
endmodule

// File: rtl/chan_fifo.sv
// chan_fifo: multi-channel FIFO over shared storage; CHAN_FIFO_DROP_COUNT_EN adds drop_count
module chan_fifo
    import chan_fifo_pkg::*;
#(
    parameter int WIDTH     = 40,
    parameter int ADDR_BITS = 3,
    parameter int CH_BITS   = 2,
    parameter int AF_LEVEL  = 2**ADDR_BITS - 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               wen,
    input  logic [CH_BITS-1:0]                 wch,
    input  logic [WIDTH-1:0]                   wdata,
    input  logic                               ren,
    input  logic [CH_BITS-1:0]                 rch,
    output logic [WIDTH-1:0]                   rdata,
    output logic                               rvalid,
    output logic [2**CH_BITS-1:0]              empty,
    output logic [2**CH_BITS-1:0]              full,
    output logic [2**CH_BITS-1:0]              almost_full,
`ifdef CHAN_FIFO_DROP_COUNT_EN
    output logic [DROP_W-1:0]                  drop_count,
`endif
    output logic [2**CH_BITS*(ADDR_BITS+1)-1:0] count
);
    localparam int CHANNELS = 2**CH_BITS;
    localparam int DEPTH    = 2**ADDR_BITS;
    localparam int CW       = ADDR_BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0]     mem [CHANNELS*DEPTH];
    logic [ADDR_BITS-1:0] rptr [CHANNELS];
    logic [ADDR_BITS-1:0] wptr [CHANNELS];
    logic [CHANNELS-1:0]  push, pop;
    logic                 same, r_ok, w_ok, bypass;

    // acceptance: a same-channel read frees a full slot and feeds an empty one
    always_comb begin
        same   = wch == rch;
        r_ok   = ren && (!empty[rch] || (wen && same));
        w_ok   = wen && (!full[wch] || (same && r_ok));
        bypass = r_ok && w_ok && same && empty[rch];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign push[c] = w_ok && !bypass && wch == CH_BITS'(c);
        assign pop[c]  = r_ok && !bypass && rch == CH_BITS'(c);
        chan_fifo_ptr #(.ADDR_BITS(ADDR_BITS)) u_ptr (
            .clock   (clock),
            .reset_n (reset_n),
            .push    (push[c]),
            .pop     (pop[c]),
            .rptr    (rptr[c]),
            .wptr    (wptr[c]),
            .count   (count[c*CW +: CW])
        );
        assign empty[c]       = count[c*CW +: CW] == '0;
        assign full[c]        = count[c*CW +: CW] == FULL_CNT;
        assign almost_full[c] = count[c*CW +: CW] >= AF_CNT;
    end

    // storage is not reset; bypassed writes never touch it
    always_ff @(posedge clock) begin
        if (w_ok && !bypass) mem[{wch, wptr[wch]}] <= wdata;
    end

    // registered read port; the head is read before a same-edge write lands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= r_ok;
            if (r_ok) rdata <= bypass ? wdata : mem[{rch, rptr[rch]}];
        end
    end

`ifdef CHAN_FIFO_DROP_COUNT_EN
    // saturating count of rejected writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) drop_count <= '0;
        else if (wen && !w_ok && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_chan_fifo.sv
// tb_chan_fifo: queue-model checked bench for chan_fifo (directed cases plus random traffic)
module tb_chan_fifo;
    import chan_fifo_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wen = 1'b0, ren = 1'b0;
    ch_idx_t     wch = '0, rch = '0;
    logic [39:0] wdata = '0;
    logic [39:0] rdata;
    logic        rvalid;
    logic [3:0]  empty, full, almost_full;
    logic [15:0] count;
`ifdef CHAN_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [39:0] mq [4][$];
    logic [39:0] exp_rdata = '0;
    logic        exp_rvalid = 1'b0;
    int          exp_drop = 0;

    chan_fifo dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wen         (wen),
        .wch         (wch),
        .wdata       (wdata),
        .ren         (ren),
        .rch         (rch),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
`ifdef CHAN_FIFO_DROP_COUNT_EN
        .drop_count  (drop_count),
`endif
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic cnt_t cnt_of(input int c);
        return cnt_t'(count >> (c * 4));
    endfunction

    // reference model: per-channel queues of depth 8
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            exp_rdata  = '0;
            exp_rvalid = 1'b0;
            exp_drop   = 0;
        end else begin
            bit r_ok, w_ok, byp;
            r_ok = ren && (mq[rch].size() > 0 || (wen && wch == rch));
            w_ok = wen && (mq[wch].size() < 8 || (r_ok && wch == rch));
            byp  = r_ok && w_ok && wch == rch && mq[rch].size() == 0;
            if (r_ok) exp_rdata = byp ? wdata : mq[rch].pop_front();
            if (w_ok && !byp) mq[wch].push_back(wdata);
            if (wen && !w_ok && exp_drop < 16'hFFFF) exp_drop++;
            exp_rvalid = r_ok;
        end
    end

    // compare DUT against model every cycle, away from the active edge
    always @(negedge clock) begin
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("count[%0d]", c), 64'(cnt_of(c)), 64'(mq[c].size()));
            chk($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(mq[c].size() == 0));
            chk($sformatf("full[%0d]", c), 64'(full[c]), 64'(mq[c].size() == 8));
            chk($sformatf("almost_full[%0d]", c), 64'(almost_full[c]), 64'(mq[c].size() >= 7));
        end
        chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
        chk("rdata", 64'(rdata), 64'(exp_rdata));
`ifdef CHAN_FIFO_DROP_COUNT_EN
        chk("drop_count", 64'(drop_count), 64'(exp_drop));
`endif
    end

    task automatic cyc(input logic w, input int wc, input logic [39:0] wd, input logic r, input int rc);
        wen   = w;
        wch   = ch_idx_t'(wc);
        wdata = wd;
        ren   = r;
        rch   = ch_idx_t'(rc);
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        chk("reset count", 64'(count), 64'h0);
        chk("reset empty", 64'(empty), 64'hF);
        chk("reset full", 64'(full), 64'h0);
        chk("reset rvalid", 64'(rvalid), 64'h0);
        chk("reset rdata", 64'(rdata), 64'h0);

        cyc(1, 1, 40'hA1, 0, 0);
        cyc(1, 1, 40'hA2, 0, 0);
        chk("ch1 count 2", 64'(cnt_of(1)), 64'd2);
        cyc(0, 0, 0, 1, 1);
        chk("ch1 rd1 data", 64'(rdata), 64'hA1);
        chk("ch1 rd1 valid", 64'(rvalid), 64'h1);
        cyc(0, 0, 0, 1, 1);
        chk("ch1 rd2 data", 64'(rdata), 64'hA2);
        chk("ch1 rd2 valid", 64'(rvalid), 64'h1);
        cyc(0, 0, 0, 0, 0);
        chk("idle rvalid", 64'(rvalid), 64'h0);
        chk("idle rdata held", 64'(rdata), 64'hA2);
        chk("ch1 count 0", 64'(cnt_of(1)), 64'd0);

        cyc(1, 2, 40'h55, 1, 2);
        chk("bypass data", 64'(rdata), 64'h55);
        chk("bypass valid", 64'(rvalid), 64'h1);
        chk("bypass empty2", 64'(empty[2]), 64'h1);

        for (int i = 0; i < 8; i++) cyc(1, 0, 40'h100 + 40'(i), 0, 0);
        chk("ch0 full", 64'(full[0]), 64'h1);
        chk("ch0 count 8", 64'(cnt_of(0)), 64'd8);
        cyc(1, 0, 40'h999, 0, 0);
        chk("ch0 drop count 8", 64'(cnt_of(0)), 64'd8);
`ifdef CHAN_FIFO_DROP_COUNT_EN
        chk("drop_count 1", 64'(drop_count), 64'd1);
`endif

        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 40'h200 + 40'(i), 1, 0);
            chk("full rw data", 64'(rdata), i < 8 ? 64'h100 + 64'(i) : 64'h200 + 64'(i - 8));
            chk("full rw count", 64'(cnt_of(0)), 64'd8);
        end

        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0);
        chk("ch0 count 1", 64'(cnt_of(0)), 64'd1);
        cyc(1, 3, 40'h33, 1, 0);
        chk("indep ch3", 64'(cnt_of(3)), 64'd1);
        chk("indep ch0", 64'(cnt_of(0)), 64'd0);
        chk("indep rdata", 64'(rdata), 64'h200 + 64'd19);
        wen = 1'b1; wch = 2'd3; wdata = 40'h44; ren = 1'b1; rch = 2'd3;
        #2 reset_n = 1'b0;
        #1;
        chk("async rst count", 64'(count), 64'h0);
        chk("async rst rvalid", 64'(rvalid), 64'h0);
        chk("async rst rdata", 64'(rdata), 64'h0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6, $urandom_range(0, 3), 40'({$urandom(), $urandom()}),
                $urandom_range(0, 9) < 5, $urandom_range(0, 3));
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/chan_fifo.md
CHAN_FIFO -- requirements
Module: chan_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 40, entry width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 3, per-channel depth DEPTH = 2**ADDR_BITS.
REQ-003 SHALL have parameter CH_BITS, default 2, channel count CHANNELS = 2**CH_BITS.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold, legal range 1..DEPTH.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wen  input  1  write request.
REQ-008 SHALL have port wch  input  CH_BITS  write channel select.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port ren  input  1  read request.
REQ-011 SHALL have port rch  input  CH_BITS  read channel select.
REQ-012 SHALL have port rdata  output  WIDTH  registered read data.
REQ-013 SHALL have port rvalid  output  1  high one cycle after an accepted read.
REQ-014 SHALL have port empty  output  CHANNELS  per-channel count==0.
REQ-015 SHALL have port full  output  CHANNELS  per-channel count==DEPTH.
REQ-016 SHALL have port almost_full  output  CHANNELS  per-channel count>=AF_LEVEL.
REQ-017 SHALL have port count  output  CHANNELS*(ADDR_BITS+1)  packed per-channel occupancy, channel 0 in LSBs.

Function
REQ-018 SHALL keep CHANNELS independent circular queues in one shared storage addressed {channel, pointer}.
REQ-019 SHALL accept a write when wen && (!full[wch] || (ren && rch==wch && read accepted)).
REQ-020 SHALL accept a read when ren && (!empty[rch] || (wen && wch==rch)).
REQ-021 SHALL, on an accepted read, drive rdata with the oldest entry of rch and assert rvalid on the next cycle (latency 1).
REQ-022 SHALL, on accepted same-channel read and write while that channel is empty, bypass: rdata <= wdata, no storage write, count unchanged.
REQ-023 SHALL, on accepted same-channel read and write while non-empty (including full), store wdata, pop head, count unchanged.
REQ-024 SHALL treat read and write on different channels as fully independent in the same cycle.
REQ-025 SHALL silently drop a rejected write; SHALL hold rdata and deassert rvalid on a rejected or absent read.
REQ-026 SHALL wrap read/write pointers modulo DEPTH with ADDR_BITS-wide natural overflow.
REQ-027 SHALL derive empty/full/almost_full combinationally from registered counts.

Reset
REQ-028 SHALL, while reset_n low, force all counts and pointers to 0, rdata to 0, rvalid to 0, independent of clock.
REQ-029 SHALL not reset storage contents; reset mid-operation discards all queued entries.

Configuration
REQ-030 SHALL, with CHAN_FIFO_DROP_COUNT_EN defined, add output drop_count (16 bits), incremented per rejected write, saturating at 0xFFFF, reset to 0.
REQ-031 SHALL, without CHAN_FIFO_DROP_COUNT_EN, omit drop_count port and its logic entirely.

Structure
REQ-032 SHALL place the channel-index and per-channel count typedefs and the drop-counter width constant in package chan_fifo_pkg.
REQ-033 SHALL instantiate one sub-module chan_fifo_ptr per channel holding read pointer, write pointer and count.

Verification
REQ-034 SHALL cover: reset, write 0xA1,0xA2 to ch1, read ch1 twice -> rdata 0xA1 then 0xA2, rvalid each cycle after read, count[1]=0.
REQ-035 SHALL cover: ch2 empty, wen+ren same cycle ch2 wdata 0x55 -> next cycle rdata 0x55, rvalid 1, empty[2] stays 1.
REQ-036 SHALL cover: fill ch0 with 8 entries, 9th write alone -> full[0]=1, count[0]=8, write dropped (drop_count=1 when macro defined).
REQ-037 SHALL cover: ch0 full, wen+ren ch0 -> both accepted, count[0] stays 8, FIFO order preserved over 20 wrapping cycles.
REQ-038 SHALL cover: write ch3 and read ch0 (holding 1 entry) same cycle -> count[3]+1, count[0]-1; then reset_n low mid-stream -> all counts 0, rvalid 0 immediately.
